// File: rtl/cpu_pkg.sv
// Shared constants and types for the MIPS32-subset core: opcode, funct and
// REGIMM rt encodings, widths, and the register index type.
package cpu_pkg;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;

  typedef logic [4:0]        reg_idx_t;
  typedef logic [WORD_W-1:0] word_t;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  localparam reg_idx_t REG_RA = 5'd31;

  function automatic word_t sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction
endpackage

// File: rtl/cpu_core.sv
// Single-cycle MIPS32-subset core with a pc/npc pair, so the instruction
// after any branch or jump (the delay slot) always executes.
module cpu_core
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic  clk,
  input  logic  rst,
  output word_t iaddr,
  input  word_t idata,
  output word_t daddr,
  input  word_t drdata,
  output logic  dwe,
  output word_t dwdata
);
  word_t       pc, npc, next_pc;
  logic [5:0]  op, funct;
  reg_idx_t    rs, rt, rd;
  logic [4:0]  sh;
  logic [15:0] imm;
  logic [25:0] index;
  word_t       rs_val, rt_val, simm, zimm, link, br_target;
  logic        rs_neg, rs_zero, st_en, wr_en;
  reg_idx_t    wr_addr;
  word_t       wr_data;

  assign op    = idata[31:26];
  assign rs    = idata[25:21];
  assign rt    = idata[20:16];
  assign rd    = idata[15:11];
  assign sh    = idata[10:6];
  assign funct = idata[5:0];
  assign imm   = idata[15:0];
  assign index = idata[25:0];

  assign simm      = sext16(imm);
  assign zimm      = {16'h0, imm};
  assign link      = pc + 32'd8;
  assign br_target = pc + 32'd4 + (simm << 2);
  assign rs_neg    = rs_val[31];
  assign rs_zero   = (rs_val == '0);

  assign iaddr  = pc;
  assign daddr  = rs_val + simm;
  assign dwdata = rt_val;
  assign dwe    = st_en & ~rst;

  cpu_regfile regfile (
    .clk(clk), .rst(rst), .ra(rs), .rb(rt), .rdata_a(rs_val), .rdata_b(rt_val),
    .we(wr_en), .wa(wr_addr), .wdata(wr_data)
  );

  always_comb begin
    next_pc = npc + 32'd4;
    wr_en   = 1'b0;
    wr_addr = rt;
    wr_data = '0;
    st_en   = 1'b0;
    case (op)
      OP_SPECIAL: begin
        wr_en   = 1'b1;
        wr_addr = rd;
        case (funct)
          FN_SLL:  wr_data = rt_val << sh;
          FN_SRL:  wr_data = rt_val >> sh;
          FN_SRA:  wr_data = word_t'($signed(rt_val) >>> sh);
          FN_ADDU: wr_data = rs_val + rt_val;
          FN_SUBU: wr_data = rs_val - rt_val;
          FN_AND:  wr_data = rs_val & rt_val;
          FN_OR:   wr_data = rs_val | rt_val;
          FN_XOR:  wr_data = rs_val ^ rt_val;
          FN_NOR:  wr_data = ~(rs_val | rt_val);
          FN_SLT:  wr_data = {31'b0, $signed(rs_val) < $signed(rt_val)};
          FN_SLTU: wr_data = {31'b0, rs_val < rt_val};
          FN_JR: begin
            wr_en   = 1'b0;
            next_pc = rs_val;
          end
          FN_JALR: begin
            wr_data = link;
            next_pc = rs_val;
          end
          default: wr_en = 1'b0;
        endcase
      end
      OP_REGIMM: begin
        // The linking forms write $31 whether or not the branch is taken.
        case (rt)
          RT_BLTZ:   if (rs_neg) next_pc = br_target;
          RT_BGEZ:   if (!rs_neg) next_pc = br_target;
          RT_BLTZAL: begin
            wr_en   = 1'b1;
            wr_addr = REG_RA;
            wr_data = link;
            if (rs_neg) next_pc = br_target;
          end
          RT_BGEZAL: begin
            wr_en   = 1'b1;
            wr_addr = REG_RA;
            wr_data = link;
            if (!rs_neg) next_pc = br_target;
          end
          default: ;
        endcase
      end
      OP_J:    next_pc = {npc[31:28], index, 2'b00};
      OP_JAL: begin
        next_pc = {npc[31:28], index, 2'b00};
        wr_en   = 1'b1;
        wr_addr = REG_RA;
        wr_data = link;
      end
      OP_BEQ:  if (rs_val == rt_val) next_pc = br_target;
      OP_BNE:  if (rs_val != rt_val) next_pc = br_target;
      OP_BLEZ: if (rs_neg || rs_zero) next_pc = br_target;
      OP_BGTZ: if (!rs_neg && !rs_zero) next_pc = br_target;
      OP_ADDIU: begin wr_en = 1'b1; wr_data = rs_val + simm; end
      OP_SLTI:  begin wr_en = 1'b1; wr_data = {31'b0, $signed(rs_val) < $signed(simm)}; end
      OP_SLTIU: begin wr_en = 1'b1; wr_data = {31'b0, rs_val < simm}; end
      OP_ANDI:  begin wr_en = 1'b1; wr_data = rs_val & zimm; end
      OP_ORI:   begin wr_en = 1'b1; wr_data = rs_val | zimm; end
      OP_XORI:  begin wr_en = 1'b1; wr_data = rs_val ^ zimm; end
      OP_LUI:   begin wr_en = 1'b1; wr_data = {imm, 16'h0}; end
      OP_LW:    begin wr_en = 1'b1; wr_data = drdata; end
      OP_SW:    st_en = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc  <= RESET_PC;
      npc <= RESET_PC + 32'd4;
    end else begin
      pc  <= npc;
      npc <= next_pc;
    end
  end
endmodule

// File: rtl/cpu_ram.sv
// Unified word-addressed RAM: combinational instruction and data reads,
// synchronous data write; addresses wrap modulo the depth.
module cpu_ram
  import cpu_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic  clk,
  input  word_t iaddr,
  output word_t idata,
  input  word_t daddr,
  output word_t drdata,
  input  logic  dwe,
  input  word_t dwdata
);
  localparam int AW = $clog2(MEM_WORDS);

  word_t          memory [0:MEM_WORDS-1];
  logic [AW-1:0]  iidx;
  logic [AW-1:0]  didx;
  logic           unused_addr_bits;

  assign iidx   = iaddr[AW+1:2];
  assign didx   = daddr[AW+1:2];
  assign idata  = memory[iidx];
  assign drdata = memory[didx];

  // Upper bits fall away so out-of-range addresses alias back into the array.
  assign unused_addr_bits = ^{iaddr[ADDR_W-1:AW+2], iaddr[1:0],
                              daddr[ADDR_W-1:AW+2], daddr[1:0]};

  always_ff @(posedge clk) begin
    if (dwe) memory[didx] <= dwdata;
  end
endmodule

// File: rtl/cpu_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write
// port; register 0 is hardwired to zero.
module cpu_regfile
  import cpu_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  reg_idx_t ra,
  input  reg_idx_t rb,
  output word_t    rdata_a,
  output word_t    rdata_b,
  input  logic     we,
  input  reg_idx_t wa,
  input  word_t    wdata
);
  word_t regs [0:31];

  // Reset has priority, so an instruction in flight during reset never lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wdata;
    end
  end

  assign rdata_a = (ra == 5'd0) ? '0 : regs[ra];
  assign rdata_b = (rb == 5'd0) ? '0 : regs[rb];
endmodule

// File: rtl/cpu_top.sv
// Self-contained system: the core (openmips) plus its unified RAM (ram).
module cpu_top
  import cpu_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic clk,
  input logic rst
);
  word_t iaddr, idata, daddr, drdata, dwdata;
  logic  dwe;

  cpu_core #(.RESET_PC(RESET_PC)) openmips (
    .clk(clk), .rst(rst), .iaddr(iaddr), .idata(idata), .daddr(daddr),
    .drdata(drdata), .dwe(dwe), .dwdata(dwdata)
  );

  cpu_ram #(.MEM_WORDS(MEM_WORDS)) ram (
    .clk(clk), .iaddr(iaddr), .idata(idata), .daddr(daddr),
    .drdata(drdata), .dwe(dwe), .dwdata(dwdata)
  );
endmodule

// File: tb/tb_cpu_top.sv
// Directed bench for cpu_top: preloads small programs into RAM and checks
// registers, pc and memory through hierarchical access.
module tb_cpu_top;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  cpu_top dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  // Hold reset across an edge, then wipe RAM so each program starts clean.
  task automatic load_start();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 1024; i++) dut.ram.memory[i] = 32'h0;
  endtask

  task automatic run(input int n);
    rst = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 1024; i++) dut.ram.memory[i] = 32'h0;
    dut.ram.memory[0]  = enc_i(6'h2b, 5'd0, 5'd0, 16'h0100);
    dut.ram.memory[64] = 32'hdead_beef;
    rst = 1'b1;
    repeat (10) @(negedge clk);
    if (dut.openmips.pc !== 32'h0) begin bad++; $display("[TB] FAIL reset_pc got=%h want=%h", dut.openmips.pc, 32'h0); end
    total++;
    if (dut.openmips.npc !== 32'h4) begin bad++; $display("[TB] FAIL reset_npc got=%h want=%h", dut.openmips.npc, 32'h4); end
    total++;
    if (dut.ram.memory[64] !== 32'hdead_beef) begin bad++; $display("[TB] FAIL reset_nowrite got=%h want=%h", dut.ram.memory[64], 32'hdead_beef); end
    total++;
    for (int i = 0; i < 32; i++) begin
      if (dut.openmips.regfile.regs[i] !== 32'h0) begin bad++; $display("[TB] FAIL reset_reg%0d got=%h want=0", i, dut.openmips.regfile.regs[i]); end
      total++;
    end
    rst = 1'b0;
    if (dut.openmips.iaddr !== 32'h0) begin bad++; $display("[TB] FAIL first_fetch got=%h want=%h", dut.openmips.iaddr, 32'h0); end
    total++;
    @(negedge clk);
    if (dut.ram.memory[64] !== 32'h0) begin bad++; $display("[TB] FAIL first_exec_sw got=%h want=%h", dut.ram.memory[64], 32'h0); end
    total++;
    if (dut.openmips.pc !== 32'h4) begin bad++; $display("[TB] FAIL pc_after_first got=%h want=%h", dut.openmips.pc, 32'h4); end
    total++;
  endtask

  task automatic test_reset_mid();
    load_start();
    dut.ram.memory[0]  = enc_i(6'h0d, 5'd0, 5'd5, 16'h0077);
    dut.ram.memory[3]  = enc_i(6'h2b, 5'd0, 5'd5, 16'h0100);
    dut.ram.memory[64] = 32'h0000_cafe;
    run(3);
    rst = 1'b1;
    @(negedge clk);
    if (dut.openmips.regfile.regs[5] !== 32'h0) begin bad++; $display("[TB] FAIL midreset_r5 got=%h want=%h", dut.openmips.regfile.regs[5], 32'h0); end
    total++;
    if (dut.openmips.pc !== 32'h0) begin bad++; $display("[TB] FAIL midreset_pc got=%h want=%h", dut.openmips.pc, 32'h0); end
    total++;
    if (dut.ram.memory[64] !== 32'h0000_cafe) begin bad++; $display("[TB] FAIL midreset_abort_sw got=%h want=%h", dut.ram.memory[64], 32'h0000_cafe); end
    total++;
  endtask

  // $2 holds the operand; taken lands at 0x14, skipping the ori at 0x10.
  task automatic run_branch(input string name, input logic [31:0] br,
                            input logic [15:0] val, input bit taken);
    logic [31:0] exp1;
    exp1 = taken ? 32'h2 : 32'h3;
    load_start();
    dut.ram.memory[0] = enc_i(6'h09, 5'd0, 5'd2, val);
    dut.ram.memory[1] = enc_i(6'h0d, 5'd0, 5'd1, 16'h0001);
    dut.ram.memory[2] = br;
    dut.ram.memory[3] = enc_i(6'h0d, 5'd0, 5'd1, 16'h0002);
    dut.ram.memory[4] = enc_i(6'h0d, 5'd0, 5'd1, 16'h0003);
    dut.ram.memory[5] = enc_i(6'h0d, 5'd0, 5'd3, 16'h0005);
    run(8);
    if (dut.openmips.regfile.regs[1] !== exp1) begin bad++; $display("[TB] FAIL %s_r1 got=%h want=%h", name, dut.openmips.regfile.regs[1], exp1); end
    total++;
    if (dut.openmips.regfile.regs[3] !== 32'h5) begin bad++; $display("[TB] FAIL %s_r3 got=%h want=%h", name, dut.openmips.regfile.regs[3], 32'h5); end
    total++;
  endtask

  task automatic test_branches();
    run_branch("beq_t",    enc_i(6'h04, 5'd2, 5'd0, 16'h2), 16'h0000, 1'b1);
    run_branch("beq_n",    enc_i(6'h04, 5'd2, 5'd0, 16'h2), 16'h0001, 1'b0);
    run_branch("bne_t",    enc_i(6'h05, 5'd2, 5'd0, 16'h2), 16'h0001, 1'b1);
    run_branch("bne_n",    enc_i(6'h05, 5'd2, 5'd0, 16'h2), 16'h0000, 1'b0);
    run_branch("bgtz_t",   enc_i(6'h07, 5'd2, 5'd0, 16'h2), 16'h0001, 1'b1);
    run_branch("bgtz_n0",  enc_i(6'h07, 5'd2, 5'd0, 16'h2), 16'h0000, 1'b0);
    run_branch("bgtz_nn",  enc_i(6'h07, 5'd2, 5'd0, 16'h2), 16'hffff, 1'b0);
    run_branch("blez_t0",  enc_i(6'h06, 5'd2, 5'd0, 16'h2), 16'h0000, 1'b1);
    run_branch("blez_tn",  enc_i(6'h06, 5'd2, 5'd0, 16'h2), 16'hffff, 1'b1);
    run_branch("blez_n",   enc_i(6'h06, 5'd2, 5'd0, 16'h2), 16'h0001, 1'b0);
    run_branch("bltz_t",   enc_i(6'h01, 5'd2, 5'd0, 16'h2), 16'hffff, 1'b1);
    run_branch("bltz_n",   enc_i(6'h01, 5'd2, 5'd0, 16'h2), 16'h0000, 1'b0);
    run_branch("bgez_t",   enc_i(6'h01, 5'd2, 5'd1, 16'h2), 16'h0000, 1'b1);
    run_branch("bgez_n",   enc_i(6'h01, 5'd2, 5'd1, 16'h2), 16'hffff, 1'b0);
  endtask

  task automatic test_not_taken();
    load_start();
    dut.ram.memory[0] = enc_i(6'h0d, 5'd0, 5'd1, 16'h0001);
    dut.ram.memory[1] = enc_i(6'h05, 5'd0, 5'd0, 16'h0004);
    dut.ram.memory[2] = enc_i(6'h0d, 5'd0, 5'd1, 16'h0002);
    dut.ram.memory[3] = enc_i(6'h0d, 5'd0, 5'd3, 16'h0007);
    dut.ram.memory[4] = enc_i(6'h0d, 5'd0, 5'd4, 16'h0009);
    run(6);
    if (dut.openmips.regfile.regs[1] !== 32'h2) begin bad++; $display("[TB] FAIL nt_delay got=%h want=%h", dut.openmips.regfile.regs[1], 32'h2); end
    total++;
    if (dut.openmips.regfile.regs[3] !== 32'h7) begin bad++; $display("[TB] FAIL nt_next got=%h want=%h", dut.openmips.regfile.regs[3], 32'h7); end
    total++;
    if (dut.openmips.regfile.regs[4] !== 32'h9) begin bad++; $display("[TB] FAIL nt_after got=%h want=%h", dut.openmips.regfile.regs[4], 32'h9); end
    total++;
  endtask

  task automatic test_link();
    load_start();
    dut.ram.memory[8]  = {6'h03, 26'h10};
    dut.ram.memory[9]  = enc_i(6'h0d, 5'd0, 5'd1, 16'h000a);
    dut.ram.memory[10] = enc_i(6'h0d, 5'd0, 5'd1, 16'h000b);
    dut.ram.memory[16] = enc_i(6'h0d, 5'd0, 5'd3, 16'h000c);
    run(12);
    if (dut.openmips.regfile.regs[31] !== 32'h28) begin bad++; $display("[TB] FAIL jal_ra got=%h want=%h", dut.openmips.regfile.regs[31], 32'h28); end
    total++;
    if (dut.openmips.regfile.regs[1] !== 32'ha) begin bad++; $display("[TB] FAIL jal_delay got=%h want=%h", dut.openmips.regfile.regs[1], 32'ha); end
    total++;
    if (dut.openmips.regfile.regs[3] !== 32'hc) begin bad++; $display("[TB] FAIL jal_target got=%h want=%h", dut.openmips.regfile.regs[3], 32'hc); end
    total++;

    for (int k = 0; k < 2; k++) begin
      load_start();
      dut.ram.memory[0] = enc_i(6'h0d, 5'd0, 5'd1, 16'h0001);
      dut.ram.memory[1] = enc_i(6'h01, 5'd1, (k == 0) ? 5'h10 : 5'h11, 16'h0002);
      dut.ram.memory[2] = enc_i(6'h0d, 5'd0, 5'd2, 16'h0002);
      dut.ram.memory[3] = enc_i(6'h0d, 5'd0, 5'd3, 16'h0003);
      run(6);
      if (dut.openmips.regfile.regs[31] !== 32'hc) begin bad++; $display("[TB] FAIL regimm_link%0d got=%h want=%h", k, dut.openmips.regfile.regs[31], 32'hc); end
      total++;
      if (dut.openmips.regfile.regs[3] !== ((k == 0) ? 32'h3 : 32'h0)) begin
        bad++; $display("[TB] FAIL regimm_path%0d got=%h want=%h", k, dut.openmips.regfile.regs[3], (k == 0) ? 32'h3 : 32'h0);
      end
      total++;
    end
  endtask

  task automatic test_reg_jumps();
    for (int k = 0; k < 2; k++) begin
      load_start();
      dut.ram.memory[0]  = enc_i(6'h0d, 5'd0, 5'd2, 16'h0060);
      dut.ram.memory[1]  = (k == 0) ? enc_r(5'd2, 5'd0, 5'd0, 5'd0, 6'h08)
                                    : enc_r(5'd2, 5'd0, 5'd3, 5'd0, 6'h09);
      dut.ram.memory[3]  = enc_i(6'h0d, 5'd0, 5'd6, 16'h0001);
      dut.ram.memory[24] = enc_i(6'h0d, 5'd0, 5'd5, 16'h0055);
      run(3);
      if (dut.openmips.pc !== 32'h60) begin bad++; $display("[TB] FAIL rj%0d_pc got=%h want=%h", k, dut.openmips.pc, 32'h60); end
      total++;
      run(1);
      if (dut.openmips.regfile.regs[5] !== 32'h55) begin bad++; $display("[TB] FAIL rj%0d_target got=%h want=%h", k, dut.openmips.regfile.regs[5], 32'h55); end
      total++;
      if (dut.openmips.regfile.regs[6] !== 32'h0) begin bad++; $display("[TB] FAIL rj%0d_skip got=%h want=%h", k, dut.openmips.regfile.regs[6], 32'h0); end
      total++;
      if (dut.openmips.regfile.regs[3] !== ((k == 0) ? 32'h0 : 32'hc)) begin
        bad++; $display("[TB] FAIL rj%0d_link got=%h want=%h", k, dut.openmips.regfile.regs[3], (k == 0) ? 32'h0 : 32'hc);
      end
      total++;
    end
  endtask

  task automatic test_mem_alu();
    load_start();
    dut.ram.memory[0]  = enc_i(6'h0d, 5'd0, 5'd1, 16'h1234);
    dut.ram.memory[1]  = enc_i(6'h2b, 5'd0, 5'd1, 16'h0100);
    dut.ram.memory[2]  = enc_i(6'h23, 5'd0, 5'd4, 16'h0100);
    dut.ram.memory[3]  = enc_i(6'h0d, 5'd0, 5'd0, 16'hffff);
    dut.ram.memory[4]  = enc_i(6'h0f, 5'd0, 5'd6, 16'h8000);
    dut.ram.memory[5]  = enc_r(5'd0, 5'd6, 5'd7, 5'd4, 6'h03);
    dut.ram.memory[6]  = enc_r(5'd0, 5'd1, 5'd8, 5'd0, 6'h23);
    dut.ram.memory[7]  = enc_r(5'd8, 5'd1, 5'd9, 5'd0, 6'h2a);
    dut.ram.memory[8]  = enc_r(5'd8, 5'd1, 5'd10, 5'd0, 6'h2b);
    dut.ram.memory[9]  = enc_r(5'd0, 5'd1, 5'd11, 5'd0, 6'h27);
    dut.ram.memory[10] = enc_i(6'h23, 5'd0, 5'd12, 16'h1100);
    run(12);
    if (dut.openmips.regfile.regs[4] !== 32'h1234) begin bad++; $display("[TB] FAIL lw_r4 got=%h want=%h", dut.openmips.regfile.regs[4], 32'h1234); end
    total++;
    if (dut.ram.memory[64] !== 32'h1234) begin bad++; $display("[TB] FAIL sw_mem64 got=%h want=%h", dut.ram.memory[64], 32'h1234); end
    total++;
    if (dut.openmips.regfile.regs[0] !== 32'h0) begin bad++; $display("[TB] FAIL r0_write got=%h want=%h", dut.openmips.regfile.regs[0], 32'h0); end
    total++;
    if (dut.openmips.regfile.regs[7] !== 32'hf800_0000) begin bad++; $display("[TB] FAIL sra got=%h want=%h", dut.openmips.regfile.regs[7], 32'hf800_0000); end
    total++;
    if (dut.openmips.regfile.regs[8] !== 32'hffff_edcc) begin bad++; $display("[TB] FAIL subu_wrap got=%h want=%h", dut.openmips.regfile.regs[8], 32'hffff_edcc); end
    total++;
    if (dut.openmips.regfile.regs[9] !== 32'h1) begin bad++; $display("[TB] FAIL slt got=%h want=%h", dut.openmips.regfile.regs[9], 32'h1); end
    total++;
    if (dut.openmips.regfile.regs[10] !== 32'h0) begin bad++; $display("[TB] FAIL sltu got=%h want=%h", dut.openmips.regfile.regs[10], 32'h0); end
    total++;
    if (dut.openmips.regfile.regs[11] !== 32'hffff_edcb) begin bad++; $display("[TB] FAIL nor got=%h want=%h", dut.openmips.regfile.regs[11], 32'hffff_edcb); end
    total++;
    if (dut.openmips.regfile.regs[12] !== 32'h1234) begin bad++; $display("[TB] FAIL lw_wrap got=%h want=%h", dut.openmips.regfile.regs[12], 32'h1234); end
    total++;
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_branches();
    test_not_taken();
    test_link();
    test_reg_jumps();
    test_mem_alu();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
